cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
// Holds the FSM state enum, instruction-type codes and the halt opcode.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [1:0] TYPE_ALU = 2'b00;
    localparam logic [1:0] TYPE_BR  = 2'b01;
    localparam logic [1:0] TYPE_IMM = 2'b10;
    localparam logic [1:0] TYPE_MEM = 2'b11;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT FSM
// plus program counter and instruction register.
// Ports: clk, reset (async, active high), start; imem_req/addr/ack/rdata
// fetch handshake; instr; branch_taken/target from the ALU; dmem_req/we/ack
// data handshake; reg_we, mem_to_reg writeback strobes; pc; retire pulse;
// done (HALT). Optional ack watchdog under SEQ_TIMEOUT_EN adds the
// TIMEOUT_CYC parameter and the sticky error output.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      instr,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_we,
    output logic            mem_to_reg,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            done
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic            error
`endif
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      instr_q, instr_d;
    logic            retire_q, retire_d;
    logic [1:0]      itype;
    logic [PC_W-1:0] pc_inc;

    assign itype  = instr_q[8:7];
    assign pc_inc = pc_q + PC_W'(1);

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             error_q, error_d;
    logic             waiting;

    // A request state with no ack this cycle.
    assign waiting = (state_q == S_FETCH && !imem_ack) ||
                     (state_q == S_MEM && !dmem_ack);
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = (imem_rdata == HALT_INSTR) ? S_HALT : S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (itype)
                    TYPE_BR: begin
                        pc_d     = branch_taken ? branch_target : pc_inc;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    TYPE_MEM: state_d = S_MEM;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (instr_q[6]) begin
                        pc_d     = pc_inc;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d     = pc_inc;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        wd_cnt_d = '0;
        error_d  = error_q;
        if ((state_q == S_IDLE || state_q == S_HALT) && start) begin
            error_d = 1'b0;
        end
        if (waiting) begin
            // Count reaching TIMEOUT_CYC abandons the access.
            if (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d = S_HALT;
                error_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // retire is registered so it is a clean one-cycle pulse following
    // the retiring transition, free of input-to-output paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    assign error = error_q;
`endif

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && instr_q[6];
    assign reg_we     = (state_q == S_WB);
    assign mem_to_reg = (state_q == S_WB) && (itype == TYPE_MEM);
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign retire     = retire_q;
    assign done       = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, random
// instruction stream against a latency/pc model, reset and watchdog cases.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_rdata;
    logic [8:0] instr;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       reg_we;
    logic       mem_to_reg;
    logic [7:0] pc;
    logic       retire;
    logic       done;
`ifdef SEQ_TIMEOUT_EN
    logic       error;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .reg_we       (reg_we),
        .mem_to_reg   (mem_to_reg),
        .pc           (pc),
        .retire       (retire),
        .done         (done)
`ifdef SEQ_TIMEOUT_EN
        ,
        .error        (error)
`endif
    );

    typedef struct {
        int         lat;
        int         ireq;
        int         dreq;
        int         regwe;
        int         nret;
        int         addr_bad;
        logic       dwe;
        logic       m2r;
        logic       done;
        logic [7:0] pc;
        logic [8:0] instr;
    } obs_t;

    typedef struct {
        logic [8:0] ins;
        logic       tk;
        logic [7:0] tg;
        int         iw;
        int         dw;
        obs_t       e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_obs(input string t, input obs_t a, input obs_t e);
        chk({t, ".lat"},   a.lat,   e.lat);
        chk({t, ".ireq"},  a.ireq,  e.ireq);
        chk({t, ".dreq"},  a.dreq,  e.dreq);
        chk({t, ".regwe"}, a.regwe, e.regwe);
        chk({t, ".retire"}, a.nret, e.nret);
        chk({t, ".addr"},  a.addr_bad, 0);
        chk({t, ".dwe"},   a.dwe,   e.dwe);
        chk({t, ".m2r"},   a.m2r,   e.m2r);
        chk({t, ".done"},  a.done,  e.done);
        chk({t, ".pc"},    a.pc,    e.pc);
        chk({t, ".instr"}, a.instr, e.instr);
    endtask

    // Behavioural expectation: latency = base + waits, pc by type rules.
    function automatic obs_t model(input logic [8:0] ins, input logic tk,
                                   input logic [7:0] tg, input int iw,
                                   input int dw, input logic [7:0] pc0);
        obs_t       e;
        logic [7:0] nxt;
        e = '{default: 0};
        nxt = pc0 + 8'd1;
        e.instr = ins;
        e.ireq = iw + 1;
        e.pc = nxt;
        if (ins == 9'h1FF) begin
            e.lat = iw + 1;
            e.done = 1'b1;
            e.pc = pc0;
            return e;
        end
        e.nret = 1;
        case (ins[8:7])
            2'b01: begin
                e.lat = 3 + iw;
                e.pc = tk ? tg : nxt;
            end
            2'b11: begin
                e.dreq = dw + 1;
                if (ins[6]) begin
                    e.lat = 4 + iw + dw;
                    e.dwe = 1'b1;
                end else begin
                    e.lat = 5 + iw + dw;
                    e.regwe = 1;
                    e.m2r = 1'b1;
                end
            end
            default: begin
                e.lat = 4 + iw;
                e.regwe = 1;
            end
        endcase
        return e;
    endfunction

    // Starts at a negedge with the DUT in its first FETCH cycle; acts as
    // instruction/data memory and ends at the negedge showing retire/done.
    task automatic exec_one(input logic [8:0] ins, input logic tk,
                            input logic [7:0] tg, input int iw,
                            input int dw, input bit noise,
                            output obs_t o);
        int fw;
        int mw;
        bit fin;
        o = '{default: 0};
        fw = 0;
        mw = 0;
        fin = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0 && retire) o.nret++;
            if (k > 0 && (retire || done)) begin
                o.lat = k;
                o.pc = pc;
                o.instr = instr;
                o.done = done;
                fin = 1;
                break;
            end
            if (imem_req) o.ireq++;
            if (imem_req && imem_addr !== pc) o.addr_bad++;
            if (dmem_req) begin
                o.dreq++;
                o.dwe |= dmem_we;
            end
            if (reg_we) begin
                o.regwe++;
                o.m2r |= mem_to_reg;
            end
            branch_taken = tk;
            branch_target = tg;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (imem_req) begin
                imem_ack = (fw == iw);
                imem_rdata = ins;
                fw++;
            end else begin
                imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = noise ? 9'($urandom) : ins;
            end
            if (dmem_req) begin
                dmem_ack = (mw == dw);
                mw++;
            end else begin
                dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!fin) chk("exec_timeout", 1, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic vec_t row(input logic [8:0] ins, input logic tk,
                                 input logic [7:0] tg, input int iw,
                                 input int dw, input int lat, input int ireq,
                                 input int dreq, input int regwe,
                                 input int nret, input logic dwe,
                                 input logic m2r, input logic dn,
                                 input logic [7:0] epc);
        vec_t v;
        v.ins = ins;
        v.tk = tk;
        v.tg = tg;
        v.iw = iw;
        v.dw = dw;
        v.e = '{default: 0};
        v.e.lat = lat;
        v.e.ireq = ireq;
        v.e.dreq = dreq;
        v.e.regwe = regwe;
        v.e.nret = nret;
        v.e.dwe = dwe;
        v.e.m2r = m2r;
        v.e.done = dn;
        v.e.pc = epc;
        v.e.instr = ins;
        return v;
    endfunction

    initial begin
        vec_t       tbl[$];
        obs_t       o;
        obs_t       e;
        logic [7:0] mpc;
        logic [8:0] ins;
        int         cnt;

        tbl.push_back(row(9'h005, 0, 8'h00, 0, 0, 4, 1, 0, 1, 1, 0, 0, 0, 8'h01));
        tbl.push_back(row(9'h100, 0, 8'h00, 0, 0, 4, 1, 0, 1, 1, 0, 0, 0, 8'h02));
        tbl.push_back(row(9'h080, 1, 8'h03, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 8'h03));
        tbl.push_back(row(9'h080, 1, 8'h20, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 8'h20));
        tbl.push_back(row(9'h080, 1, 8'h03, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 8'h03));
        tbl.push_back(row(9'h080, 0, 8'h20, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 8'h04));
        tbl.push_back(row(9'h180, 0, 8'h00, 0, 3, 8, 1, 4, 1, 1, 0, 1, 0, 8'h05));
        tbl.push_back(row(9'h080, 1, 8'hFF, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 8'hFF));
        tbl.push_back(row(9'h1C0, 0, 8'h00, 0, 0, 4, 1, 1, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(row(9'h03F, 0, 8'h00, 2, 0, 6, 3, 0, 1, 1, 0, 0, 0, 8'h01));
        tbl.push_back(row(9'h1C5, 0, 8'h00, 0, 2, 6, 1, 3, 0, 1, 1, 0, 0, 8'h02));
        tbl.push_back(row(9'h1FF, 0, 8'h00, 1, 0, 2, 2, 0, 0, 0, 0, 0, 1, 8'h02));

        reset = 1'b1;
        start = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        dmem_ack = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;

        @(negedge clk);
        chk("rst_outs", {imem_req, dmem_req, dmem_we, reg_we, mem_to_reg,
                         retire, done}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
`ifdef SEQ_TIMEOUT_EN
        chk("rst_error", error, 0);
`endif
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req || done || retire) cnt++;
        end
        chk("idle_hold", cnt, 0);

        do_start();
        chk("start_fetch", imem_req, 1);
        chk("start_pc", pc, 0);

        foreach (tbl[i]) begin
            exec_one(tbl[i].ins, tbl[i].tk, tbl[i].tg, tbl[i].iw, tbl[i].dw,
                     0, o);
            check_obs($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Halted: requests off, then start resumes at pc 0.
        chk("halt_reqs", {imem_req, dmem_req, reg_we, retire}, 0);
        do_start();
        chk("restart_fetch", imem_req, 1);
        chk("restart_pc", pc, 0);
        chk("restart_done", done, 0);

        mpc = 8'h00;
        for (int n = 0; n < 150; n++) begin
            int         iw;
            int         dw;
            logic       tk;
            logic [7:0] tg;
            if ($urandom_range(0, 19) == 0) begin
                ins = 9'h1FF;
            end else begin
                ins = 9'($urandom);
                if (ins == 9'h1FF) ins = 9'h1FE;
            end
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            tk = 1'($urandom_range(0, 1));
            tg = 8'($urandom);
            if ($urandom_range(0, 7) == 0) tg = mpc;
            e = model(ins, tk, tg, iw, dw, mpc);
            exec_one(ins, tk, tg, iw, dw, 1, o);
            check_obs($sformatf("rnd%0d", n), o, e);
            mpc = e.pc;
            if (e.done) begin
                do_start();
                mpc = 8'h00;
            end
        end

        // Reset mid-MEM drops the request asynchronously.
        imem_rdata = 9'h180;
        imem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        cnt = 0;
        while (!dmem_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("mem_reached", dmem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_dreq", dmem_req, 0);
        chk("async_pc", pc, 0);
        chk("async_instr", instr, 0);
        chk("async_retire", retire, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_req || dmem_req || done || retire || pc != 0) cnt++;
        end
        chk("post_rst_idle", cnt, 0);

`ifdef SEQ_TIMEOUT_EN
        do_start();
        imem_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (imem_req) cnt++;
            @(negedge clk);
        end
        chk("wd_cycles", cnt, 15);
        chk("wd_done", done, 1);
        chk("wd_error", error, 1);
        @(negedge clk);
        chk("wd_sticky", error, 1);
        do_start();
        chk("wd_clear", error, 0);
        chk("wd_refetch", imem_req, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
